// File: rtl/mb_rx_framer_pkg.sv
// Shared definitions for the Modbus RX framer: FSM encoding, CRC/ASCII constants
// and the byte-level CRC-16 and hex-decode helpers.
package mb_rx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'hA001;

    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    // Reflected CRC-16 (Modbus), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Returns {valid, nibble}; valid=0 for anything that is not a hex digit.
    function automatic logic [4:0] hex2nib(input logic [7:0] ch);
        logic [7:0] d;
        d = 8'h00;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            d = ch - 8'h30;
            return {1'b1, d[3:0]};
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            d = ch - 8'h37;
            return {1'b1, d[3:0]};
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            d = ch - 8'h57;
            return {1'b1, d[3:0]};
        end
        return 5'h00;
    endfunction

endpackage

// File: rtl/mb_rx_framer_ram.sv
// Single-write, single-read synchronous byte RAM holding one frame.
// Read data is registered (one cycle latency) and cleared by reset.
module mb_rx_framer_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mb_rx_framer.sv
// Modbus RX framer: buffers one RTU or ASCII frame, checks CRC/LRC and slave
// address, then holds the frame for the controller until acknowledged.
module mb_rx_framer
    import mb_rx_framer_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ascii_en,
    input  logic [7:0]    my_addr,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          frame_start_i,
    input  logic          frame_end_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          frm_valid_o,
    output logic [AW:0]   frm_len_o,
    output logic          frm_bcast_o,
    input  logic          frm_ack_i,
    output logic          crc_err_o,
    output logic          lrc_err_o,
    output logic          ovf_err_o,
    output logic          busy_drop_o,
    output logic [1:0]    dbg_state
);

    // Handshake: frm_valid_o rises with a checked frame and stays high until
    // frm_ack_i is sampled high in HOLD; it falls on that same clock edge.

    localparam logic [AW:0] PTR_FULL = {1'b1, {AW{1'b0}}};

    state_e        state, state_nxt;
    logic [AW:0]   wr_ptr, wr_ptr_n;
    logic [15:0]   crc, crc_n;
    logic [7:0]    lrc, lrc_n;
    logic          nib_pend, nib_pend_n;
    logic [3:0]    nib_hi, nib_hi_n;
    logic          fmt_err, fmt_err_n;
    logic          ovf, ovf_n;
    logic [7:0]    addr_byte, addr_byte_n;
    logic          ascii_mode, ascii_mode_n;

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    logic          start_frame;
    logic          take_byte;
    logic          mode;
    logic [4:0]    hx;
    logic [7:0]    dec;

    logic          frm_valid_n, frm_bcast_n;
    logic [AW:0]   frm_len_n;
    logic          crc_err_n, lrc_err_n, ovf_err_n, busy_drop_n;
    logic          bad_frame;

    assign dbg_state = state;

    // A frame (re)starts only while idle or receiving; HOLD and CHECK drop it.
    assign start_frame = frame_start_i && (state == ST_IDLE || state == ST_RECV);
    assign take_byte   = rx_valid_i && (start_frame || state == ST_RECV);
    assign mode        = start_frame ? ascii_en : ascii_mode;

    always_comb begin
        wr_ptr_n     = wr_ptr;
        crc_n        = crc;
        lrc_n        = lrc;
        nib_pend_n   = nib_pend;
        nib_hi_n     = nib_hi;
        fmt_err_n    = fmt_err;
        ovf_n        = ovf;
        addr_byte_n  = addr_byte;
        ascii_mode_n = ascii_mode;
        we           = 1'b0;
        waddr        = wr_ptr[AW-1:0];
        wdata        = rx_data_i;
        hx           = hex2nib(rx_data_i);
        dec          = {nib_hi, hx[3:0]};

        if (start_frame) begin
            wr_ptr_n     = '0;
            crc_n        = CRC16_INIT;
            lrc_n        = 8'h00;
            nib_pend_n   = 1'b0;
            fmt_err_n    = 1'b0;
            ovf_n        = 1'b0;
            ascii_mode_n = ascii_en;
        end

        if (take_byte) begin
            if (!mode) begin
                if (wr_ptr_n == PTR_FULL) begin
                    ovf_n = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = wr_ptr_n[AW-1:0];
                    wdata = rx_data_i;
                    if (wr_ptr_n == '0) addr_byte_n = rx_data_i;
                    crc_n    = crc16_byte(crc_n, rx_data_i);
                    wr_ptr_n = wr_ptr_n + (AW+1)'(1);
                end
            end else if (rx_data_i == ASC_COLON) begin
                // A colon always begins a fresh frame, even mid-frame.
                wr_ptr_n   = '0;
                lrc_n      = 8'h00;
                nib_pend_n = 1'b0;
                fmt_err_n  = 1'b0;
                ovf_n      = 1'b0;
            end else if (rx_data_i == ASC_CR || rx_data_i == ASC_LF) begin
                wr_ptr_n = wr_ptr_n;
            end else if (!hx[4]) begin
                fmt_err_n = 1'b1;
            end else if (!nib_pend_n) begin
                nib_hi_n   = hx[3:0];
                nib_pend_n = 1'b1;
            end else begin
                nib_pend_n = 1'b0;
                dec        = {nib_hi_n, hx[3:0]};
                if (wr_ptr_n == PTR_FULL) begin
                    ovf_n = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = wr_ptr_n[AW-1:0];
                    wdata = dec;
                    if (wr_ptr_n == '0) addr_byte_n = dec;
                    lrc_n    = lrc_n + dec;
                    wr_ptr_n = wr_ptr_n + (AW+1)'(1);
                end
            end
        end
    end

    assign bad_frame = ascii_mode
        ? (wr_ptr < (AW+1)'(3) || fmt_err || nib_pend || lrc != 8'h00)
        : (wr_ptr < (AW+1)'(4) || crc != 16'h0000);

    always_comb begin
        state_nxt   = state;
        frm_len_n   = frm_len_o;
        frm_bcast_n = frm_bcast_o;
        crc_err_n   = 1'b0;
        lrc_err_n   = 1'b0;
        ovf_err_n   = 1'b0;
        busy_drop_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (frame_start_i) state_nxt = ST_RECV;
            end
            ST_RECV: begin
                if (frame_end_i) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                if (ovf) begin
                    ovf_err_n = 1'b1;
                end else if (bad_frame) begin
                    lrc_err_n = ascii_mode;
                    crc_err_n = !ascii_mode;
                end else if (addr_byte == my_addr || addr_byte == 8'h00) begin
                    state_nxt   = ST_HOLD;
                    frm_len_n   = ascii_mode ? (wr_ptr - (AW+1)'(1)) : (wr_ptr - (AW+1)'(2));
                    frm_bcast_n = (addr_byte == 8'h00);
                end
            end
            ST_HOLD: begin
                busy_drop_n = frame_start_i;
                if (frm_ack_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state_nxt != ST_HOLD) begin
            frm_len_n   = '0;
            frm_bcast_n = 1'b0;
        end
        frm_valid_n = (state_nxt == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            crc         <= CRC16_INIT;
            lrc         <= 8'h00;
            nib_pend    <= 1'b0;
            nib_hi      <= 4'h0;
            fmt_err     <= 1'b0;
            ovf         <= 1'b0;
            addr_byte   <= 8'h00;
            ascii_mode  <= 1'b0;
            frm_valid_o <= 1'b0;
            frm_len_o   <= '0;
            frm_bcast_o <= 1'b0;
            crc_err_o   <= 1'b0;
            lrc_err_o   <= 1'b0;
            ovf_err_o   <= 1'b0;
            busy_drop_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_n;
            crc         <= crc_n;
            lrc         <= lrc_n;
            nib_pend    <= nib_pend_n;
            nib_hi      <= nib_hi_n;
            fmt_err     <= fmt_err_n;
            ovf         <= ovf_n;
            addr_byte   <= addr_byte_n;
            ascii_mode  <= ascii_mode_n;
            frm_valid_o <= frm_valid_n;
            frm_len_o   <= frm_len_n;
            frm_bcast_o <= frm_bcast_n;
            crc_err_o   <= crc_err_n;
            lrc_err_o   <= lrc_err_n;
            ovf_err_o   <= ovf_err_n;
            busy_drop_o <= busy_drop_n;
        end
    end

    mb_rx_framer_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_addr_i),
        .rdata (rd_data_o)
    );

endmodule
